// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// inst_fetch_ctrl_pkg : bus widths, constants and FSM encoding shared by the
//                       instruction fetch controller and its watchdog.
// Revision: 1.0
// ============================================================================
package inst_fetch_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic               RstEnable = 1'b0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    function automatic logic word_aligned(input logic [InstAddrBus-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl_timer.sv
`default_nettype none
// ============================================================================
// ifc_timer : watchdog for an outstanding fetch; expires on the
//             TIMEOUT_CYCLES-th enabled cycle after a clear.
// Revision: 1.0
// ============================================================================
module ifc_timer
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle that would take the count to TIMEOUT_CYCLES is the expiry cycle.
    assign expired_o = enable_i & (cnt_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// inst_fetch_ctrl : one-entry instruction buffer in front of a request/ack
//                   memory port, with misalignment and watchdog error pulses.
// Revision: 1.0
// ============================================================================
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [InstBus-1:0]     rom_data_o,
    output logic                   stallreq_o,
    input  logic                   flush_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [InstBus-1:0]     mem_rdata_i,
    output logic                   fetch_err_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] mem_addr_q, mem_addr_d;
    logic [InstAddrBus-1:0] buf_addr_q, buf_addr_d;
    logic [InstBus-1:0]     buf_data_q, buf_data_d;
    logic                   buf_valid_q, buf_valid_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   fetch_err_q, fetch_err_d;

    logic misaligned;
    logic hit;
    logic miss;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    ifc_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    always_comb begin
        misaligned = rom_ce_i & ~word_aligned(rom_addr_i);
        hit        = rom_ce_i & buf_valid_q & (rom_addr_i == buf_addr_q);
        miss       = rom_ce_i & ~misaligned & ~hit;
        stallreq_o = miss;
        rom_data_o = (hit & ~misaligned) ? buf_data_q : ZeroWord;
    end

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        buf_valid_d  = buf_valid_q;
        flush_pend_d = flush_pend_q;
        fetch_err_d  = misaligned;
        tmr_clear    = 1'b0;
        tmr_enable   = 1'b0;

        case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                if (flush_i) begin
                    buf_valid_d = 1'b0;
                end
                if (miss) begin
                    state_d    = WAIT;
                    mem_addr_d = rom_addr_i;
                    tmr_clear  = 1'b1;
                end
            end
            WAIT: begin
                tmr_enable = ~mem_ack_i;
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                    buf_valid_d  = 1'b0;
                end
                if (mem_ack_i | tmr_expired) begin
                    state_d      = IDLE;
                    flush_pend_d = 1'b0;
                    // A flush seen at any point of the transaction drops the fill.
                    if (flush_i | flush_pend_q) begin
                        buf_valid_d = 1'b0;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = mem_addr_q;
                        buf_data_d  = mem_ack_i ? mem_rdata_i : ZeroWord;
                    end
                    if (!mem_ack_i) begin
                        fetch_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            buf_addr_q   <= '0;
            buf_data_q   <= ZeroWord;
            buf_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            buf_valid_q  <= buf_valid_d;
            flush_pend_q <= flush_pend_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign mem_req_o   = (state_q == WAIT);
    assign mem_addr_o  = mem_addr_q;
    assign fetch_err_o = fetch_err_q;

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max WAIT cycles before a fetch is aborted.
REQ-002 Parameter CNT_W, default 8, width of the watchdog counter; TIMEOUT_CYCLES SHALL be below 2^CNT_W.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rom_ce_i  input  1  fetch enable from CPU pc stage.
REQ-006 rom_addr_i  input  32  fetch byte address from CPU.
REQ-007 rom_data_o  output  32  instruction returned to CPU IF/ID.
REQ-008 stallreq_o  output  1  fetch not yet satisfied; CPU SHALL hold pc.
REQ-009 flush_i  input  1  invalidate the fetch buffer.
REQ-010 mem_req_o  output  1  external memory read request.
REQ-011 mem_addr_o  output  32  external memory word address.
REQ-012 mem_ack_i  input  1  external memory read data valid.
REQ-013 mem_rdata_i  input  32  external memory read data.
REQ-014 fetch_err_o  output  1  one-cycle pulse on misaligned fetch or watchdog timeout.

Function
REQ-015 One-entry buffer: buf_valid, buf_addr[31:0], buf_data[31:0]; hit = rom_ce_i & buf_valid & (rom_addr_i == buf_addr).
REQ-016 Misaligned = rom_ce_i & (rom_addr_i[1:0] != 0); no bus access; rom_data_o = 0 (NOP); stallreq_o = 0; fetch_err_o pulses in the next cycle.
REQ-017 rom_ce_i = 0: rom_data_o = 0, stallreq_o = 0; no new request.
REQ-018 Hit: rom_data_o = buf_data combinationally, stallreq_o = 0, same cycle.
REQ-019 Miss (rom_ce_i, aligned, not hit): stallreq_o = 1 combinationally until hit.
REQ-020 FSM states IDLE and WAIT only; reset state IDLE.
REQ-021 IDLE -> WAIT on miss; registers mem_addr_o = rom_addr_i, mem_req_o = 1, clears counter.
REQ-022 In WAIT, mem_req_o stays 1 and mem_addr_o stays stable until the cycle mem_ack_i = 1 is sampled.
REQ-023 WAIT with mem_ack_i = 1 -> IDLE; buf_data = mem_rdata_i, buf_addr = mem_addr_o, buf_valid = 1, mem_req_o = 0.
REQ-024 Minimum miss penalty: 2 stall cycles (request cycle plus fill cycle) with ack in the first WAIT cycle.
REQ-025 Counter increments each WAIT cycle without ack; when count reaches TIMEOUT_CYCLES -> IDLE, buffer filled with data 0 at mem_addr_o, buf_valid = 1, fetch_err_o pulses.
REQ-026 rom_addr_i or rom_ce_i changing during WAIT SHALL NOT abort the transaction; the new address is evaluated in IDLE afterwards.
REQ-027 flush_i in IDLE: buf_valid = 0 next cycle.
REQ-028 flush_i during WAIT, or in the same cycle as ack or timeout: the transaction completes, the fill is discarded, and buf_valid = 0.
REQ-029 mem_ack_i outside WAIT SHALL be ignored.

Reset
REQ-030 On rst = 0, immediately: state IDLE, mem_req_o = 0, mem_addr_o = 0, buf_valid = 0, buf_addr = 0, buf_data = 0, counter = 0, fetch_err_o = 0.
REQ-031 Reset during WAIT abandons the transaction; a later mem_ack_i SHALL be ignored.

Structure
REQ-032 The shared defines file SHALL hold InstAddrBus, InstBus, ZeroWord, the IDLE/WAIT state encodings, and the RstEnable value (1'b0).
REQ-033 The watchdog SHALL be one sub-module, ifc_timer (clear, enable, expired), parameterised by TIMEOUT_CYCLES and CNT_W.

Verification
REQ-034 Fetch 0x00000000, memory acks 0x34011100 on the first WAIT cycle -> stallreq_o high 2 cycles, then rom_data_o = 0x34011100 and stallreq_o = 0.
REQ-035 Repeat 0x00000000 after fill -> hit: zero stall, no mem_req_o.
REQ-036 Address 0x00000006 -> rom_data_o = 0, fetch_err_o pulse, mem_req_o never rises.
REQ-037 Memory never acks, TIMEOUT_CYCLES = 4 -> mem_req_o high 4 cycles, then fetch_err_o pulse and rom_data_o = 0.
REQ-038 flush_i asserted with mem_ack_i -> next fetch of the same address misses and re-requests.
REQ-039 rst low mid-WAIT, then ack -> mem_req_o = 0 immediately, buffer stays invalid.
